// File: rtl/lsu_align_ctrl_if.sv
// ---------------------------------------------------------------------------
// lsu_align_ctrl_if
//   Bundles the execute-side request/response handshake and the byte-enabled
//   data memory port of the load/store alignment controller.
//
//   slave  : the controller (lsu_align_ctrl)
//   master : the environment (execute stage + data memory)
//
//   Request  : req_valid, req_ready, req_addr, req_wdata, req_load, req_dw,
//              req_sign
//   Memory   : mem_addr, mem_re, mem_we, mem_be, mem_wdata, mem_rdata
//   Response : rsp_valid, rsp_rdata, rsp_err
// ---------------------------------------------------------------------------
interface lsu_align_ctrl_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              req_load;
  logic [1:0]        req_dw;
  logic              req_sign;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_re;
  logic              mem_we;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;

  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport slave (
    input  req_valid, req_addr, req_wdata, req_load, req_dw, req_sign,
    input  mem_rdata,
    output req_ready,
    output mem_addr, mem_re, mem_we, mem_be, mem_wdata,
    output rsp_valid, rsp_rdata, rsp_err
  );

  modport master (
    output req_valid, req_addr, req_wdata, req_load, req_dw, req_sign,
    output mem_rdata,
    input  req_ready,
    input  mem_addr, mem_re, mem_we, mem_be, mem_wdata,
    input  rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/lsu_align_ctrl.sv
// ---------------------------------------------------------------------------
// lsu_align_ctrl
//   Load/store alignment controller between the execute stage and a
//   byte-enabled, word-wide data memory with 1-cycle read latency.
//   Each accepted byte/half/word request becomes one word access, or two when
//   it crosses a 4-byte boundary. Load data is merged, masked and optionally
//   sign-extended; one registered response pulse is returned per request.
//
// Ports:
//   clk  - clock, all state updates on posedge
//   rst  - synchronous reset, active-high
//   bus  - lsu_align_ctrl_if.slave (request, memory and response signals)
//
// Parameters:
//   ADDR_W - byte-address width (mem_addr[1:0] is always 0)
//
// Build option:
//   MISALIGN_TRAP_EN - when defined, any request whose byte offset is not a
//   multiple of its size is rejected with rsp_err instead of being split.
// ---------------------------------------------------------------------------
module lsu_align_ctrl #(
  parameter int unsigned ADDR_W = 32
) (
  input logic             clk,
  input logic             rst,
  lsu_align_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE0,
    ISSUE1,
    DRAIN,
    RESP
  } state_e;

  typedef enum logic [1:0] {
    DW_B   = 2'd0,
    DW_H   = 2'd1,
    DW_W   = 2'd2,
    DW_BAD = 2'd3
  } dw_e;

  // Lane span over two consecutive words: bits [3:0] are word 0 lanes,
  // bits [7:4] are word 1 lanes. Non-zero upper half means a split access.
  function automatic logic [7:0] lane_span(input dw_e dw, input logic [1:0] o);
    logic [7:0] m;
    case (dw)
      DW_B:    m = 8'h01;
      DW_H:    m = 8'h03;
      default: m = 8'h0F;
    endcase
    return m << o;
  endfunction

  // Store data masked to its size and rotated into lane position; the same
  // value serves both words of a split store.
  function automatic logic [31:0] lane_wdata(input dw_e dw, input logic [1:0] o,
                                             input logic [31:0] w);
    logic [31:0] m;
    case (dw)
      DW_B:    m = {24'h0, w[7:0]};
      DW_H:    m = {16'h0, w[15:0]};
      default: m = w;
    endcase
    case (o)
      2'd0:    return m;
      2'd1:    return {m[23:0], m[31:24]};
      2'd2:    return {m[15:0], m[31:16]};
      default: return {m[7:0],  m[31:8]};
    endcase
  endfunction

  // ({hi,lo} >> 8*o)[31:0], masked and extended. Only hi[23:0] can ever
  // reach the result, since o is at most 3.
  function automatic logic [31:0] load_result(input logic [23:0] hi,
                                              input logic [31:0] lo,
                                              input logic [1:0]  o,
                                              input dw_e         dw,
                                              input logic        sgn);
    logic [31:0] r;
    case (o)
      2'd0:    r = lo;
      2'd1:    r = {hi[7:0],  lo[31:8]};
      2'd2:    r = {hi[15:0], lo[31:16]};
      default: r = {hi[23:0], lo[31:24]};
    endcase
    case (dw)
      DW_B:    return {{24{sgn & r[7]}},  r[7:0]};
      DW_H:    return {{16{sgn & r[15]}}, r[15:0]};
      default: return r;
    endcase
  endfunction

  state_e            state;
  logic [ADDR_W-1:0] addr_q;
  logic              load_q;
  dw_e               dw_q;
  logic              sign_q;
  logic              split_q;
  logic [3:0]        be1_q;
  logic [31:0]       wlane_q;
  logic [31:0]       lo_q;

  dw_e               req_dw_e;
  logic [1:0]        req_o;
  logic [7:0]        req_span;
  logic [31:0]       req_wlane;
  logic              req_reject;
  logic [31:0]       drain_lo;
  logic [23:0]       drain_hi;
  logic [31:0]       drain_result;
  logic [ADDR_W-1:0] word1_addr;

  always_comb begin
    req_dw_e  = dw_e'(bus.req_dw);
    req_o     = bus.req_addr[1:0];
    req_span  = lane_span(req_dw_e, req_o);
    req_wlane = lane_wdata(req_dw_e, req_o, bus.req_wdata);
`ifdef MISALIGN_TRAP_EN
    req_reject = (req_dw_e == DW_BAD)
              || ((req_dw_e == DW_H) && req_o[0])
              || ((req_dw_e == DW_W) && (req_o != 2'd0));
`else
    req_reject = (req_dw_e == DW_BAD);
`endif
  end

  // In DRAIN the word arriving on mem_rdata is the low word for a single
  // access and the high word for a split one (low word was captured in ISSUE1).
  always_comb begin
    drain_lo     = split_q ? lo_q : bus.mem_rdata;
    drain_hi     = split_q ? bus.mem_rdata[23:0] : 24'h0;
    drain_result = load_result(drain_hi, drain_lo, addr_q[1:0], dw_q, sign_q);
    word1_addr   = {addr_q[ADDR_W-1:2] + (ADDR_W-2)'(1), 2'b00};
  end

  // All outputs are registered: each transition loads the values for the
  // state being entered, so strobes default low every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      bus.req_ready <= 1'b1;
      bus.mem_addr  <= '0;
      bus.mem_re    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_be    <= '0;
      bus.mem_wdata <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_rdata <= '0;
      bus.rsp_err   <= 1'b0;
      addr_q        <= '0;
      load_q        <= 1'b0;
      dw_q          <= DW_B;
      sign_q        <= 1'b0;
      split_q       <= 1'b0;
      be1_q         <= '0;
      wlane_q       <= '0;
      lo_q          <= '0;
    end else begin
      bus.mem_addr  <= '0;
      bus.mem_re    <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_be    <= '0;
      bus.mem_wdata <= '0;
      bus.rsp_valid <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            bus.req_ready <= 1'b0;
            addr_q        <= bus.req_addr;
            load_q        <= bus.req_load;
            dw_q          <= req_dw_e;
            sign_q        <= bus.req_sign;
            split_q       <= |req_span[7:4];
            be1_q         <= req_span[7:4];
            wlane_q       <= bus.req_load ? 32'h0 : req_wlane;
            if (req_reject) begin
              state         <= RESP;
              bus.rsp_valid <= 1'b1;
              bus.rsp_err   <= 1'b1;
              bus.rsp_rdata <= '0;
            end else begin
              state         <= ISSUE0;
              bus.mem_addr  <= {bus.req_addr[ADDR_W-1:2], 2'b00};
              bus.mem_re    <= bus.req_load;
              bus.mem_we    <= ~bus.req_load;
              bus.mem_be    <= req_span[3:0];
              bus.mem_wdata <= bus.req_load ? 32'h0 : req_wlane;
            end
          end
        end

        ISSUE0: begin
          if (split_q) begin
            state         <= ISSUE1;
            bus.mem_addr  <= word1_addr;
            bus.mem_re    <= load_q;
            bus.mem_we    <= ~load_q;
            bus.mem_be    <= be1_q;
            bus.mem_wdata <= wlane_q;
          end else if (load_q) begin
            state <= DRAIN;
          end else begin
            state         <= RESP;
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= 1'b0;
            bus.rsp_rdata <= '0;
          end
        end

        ISSUE1: begin
          if (load_q) begin
            lo_q  <= bus.mem_rdata;
            state <= DRAIN;
          end else begin
            state         <= RESP;
            bus.rsp_valid <= 1'b1;
            bus.rsp_err   <= 1'b0;
            bus.rsp_rdata <= '0;
          end
        end

        DRAIN: begin
          state         <= RESP;
          bus.rsp_valid <= 1'b1;
          bus.rsp_err   <= 1'b0;
          bus.rsp_rdata <= drain_result;
        end

        RESP: begin
          state         <= IDLE;
          bus.req_ready <= 1'b1;
          bus.rsp_err   <= 1'b0;
          bus.rsp_rdata <= '0;
        end

        default: begin
          state         <= IDLE;
          bus.req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_align_ctrl.sv
// Bench for lsu_align_ctrl: word-addressed memory model with 1-cycle read
// latency, response scoreboard checked by a monitor, per-scenario tasks.
module tb_lsu_align_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  lsu_align_ctrl_if #(.ADDR_W(32)) bus ();

  lsu_align_ctrl #(.ADDR_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  exp_t        exp_q[$];
  int          tests_run = 0;
  int          fails     = 0;
  int          cyc       = 0;
  int          accept_cyc = 0;
  logic [31:0] mem [64];

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: 64 words indexed by addr[7:2]; garbage when not reading.
  always @(posedge clk) begin
    if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr[7:2]];
    else            bus.mem_rdata <= 32'hBAD0BAD0;
    if (bus.mem_we)
      for (int b = 0; b < 4; b++)
        if (bus.mem_be[b]) mem[bus.mem_addr[7:2]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
  end

  // Response monitor / scoreboard.
  always @(negedge clk) begin
    exp_t e;
    int   lat_obs;
    if (!rst) begin
      tests_run++;
      if (bus.mem_re && bus.mem_we) begin
        fails++;
        $display("FAIL strobe_excl: mem_re=%b mem_we=%b required not both 1", bus.mem_re, bus.mem_we);
      end
      if (bus.rsp_valid === 1'b1) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL unexpected_rsp: rsp_valid=1 rdata=%h required no response", bus.rsp_rdata);
        end else begin
          e = exp_q.pop_front();
          lat_obs = cyc - accept_cyc + 1;
          if (bus.rsp_rdata !== e.rdata || bus.rsp_err !== e.err || lat_obs != e.lat) begin
            fails++;
            $display("FAIL rsp: rdata=%h err=%b cycle=%0d required rdata=%h err=%b cycle=%0d",
                     bus.rsp_rdata, bus.rsp_err, lat_obs, e.rdata, e.err, e.lat);
          end
        end
      end
    end
  end

  task automatic send(input logic ld, input logic [1:0] dw, input logic sg,
                      input logic [31:0] addr, input logic [31:0] wd,
                      input logic [31:0] exp_rd, input logic exp_err, input int lat,
                      input logic expect_rsp);
    int waited = 0;
    @(negedge clk);
    while (bus.req_ready !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    tests_run++;
    if (bus.req_ready !== 1'b1) begin
      fails++;
      $display("FAIL send_ready: req_ready=%b required 1", bus.req_ready);
    end
    bus.req_load  = ld;
    bus.req_dw    = dw;
    bus.req_sign  = sg;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
    bus.req_valid = 1'b1;
    if (expect_rsp) exp_q.push_back('{rdata: exp_rd, err: exp_err, lat: lat});
    @(posedge clk);
    #1;
    accept_cyc    = cyc;
    bus.req_valid = 1'b0;
    bus.req_addr  = $urandom;
    bus.req_wdata = $urandom;
    bus.req_load  = 1'($urandom);
    bus.req_dw    = 2'($urandom);
    bus.req_sign  = 1'($urandom);
  endtask

  task automatic drain_q(input string name);
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    tests_run++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s_timeout: %0d responses outstanding required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests_run++;
    if ({bus.req_ready, bus.mem_re, bus.mem_we, bus.mem_be} !== 7'b1_0_0_0000) begin
      fails++;
      $display("FAIL reset_ctrl: ready/re/we/be=%b required 1000000",
               {bus.req_ready, bus.mem_re, bus.mem_we, bus.mem_be});
    end
    tests_run++;
    if ({bus.mem_addr, bus.mem_wdata} !== 64'h0) begin
      fails++;
      $display("FAIL reset_mem: addr=%h wdata=%h required 0", bus.mem_addr, bus.mem_wdata);
    end
    tests_run++;
    if ({bus.rsp_valid, bus.rsp_err, bus.rsp_rdata} !== 34'h0) begin
      fails++;
      $display("FAIL reset_rsp: valid=%b err=%b rdata=%h required 0",
               bus.rsp_valid, bus.rsp_err, bus.rsp_rdata);
    end
    rst = 1'b0;
  endtask

  task automatic test_aligned_load();
    mem[0] <= 32'hDEADBEEF;
    send(1'b1, 2'd2, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 3, 1'b1);
    @(negedge clk);
    tests_run++;
    if ({bus.mem_re, bus.mem_we, bus.mem_be, bus.mem_addr} !== {1'b1, 1'b0, 4'hF, 32'h100}) begin
      fails++;
      $display("FAIL lw_c1: re/we/be/addr=%h required %h",
               {bus.mem_re, bus.mem_we, bus.mem_be, bus.mem_addr}, {1'b1, 1'b0, 4'hF, 32'h100});
    end
    @(negedge clk);
    tests_run++;
    if ({bus.mem_re, bus.mem_we, bus.mem_be, bus.mem_addr} !== 38'h0) begin
      fails++;
      $display("FAIL lw_c2_idle: re/we/be/addr=%h required 0",
               {bus.mem_re, bus.mem_we, bus.mem_be, bus.mem_addr});
    end
    drain_q("lw");
  endtask

  task automatic test_byte_loads();
    mem[0] <= 32'h80112233;
    send(1'b1, 2'd0, 1'b1, 32'h103, 32'h0, 32'hFFFFFF80, 1'b0, 3, 1'b1);
    @(negedge clk);
    tests_run++;
    if (bus.mem_be !== 4'b1000) begin
      fails++;
      $display("FAIL lb_be: be=%b required 1000", bus.mem_be);
    end
    drain_q("lb_s");
    send(1'b1, 2'd0, 1'b0, 32'h103, 32'h0, 32'h00000080, 1'b0, 3, 1'b1);
    drain_q("lb_u");
    send(1'b1, 2'd1, 1'b1, 32'h102, 32'h0, 32'hFFFF8011, 1'b0, 3, 1'b1);
    @(negedge clk);
    tests_run++;
    if (bus.mem_be !== 4'b1100) begin
      fails++;
      $display("FAIL lh_be: be=%b required 1100", bus.mem_be);
    end
    drain_q("lh_s");
    send(1'b1, 2'd0, 1'b1, 32'h100, 32'h0, 32'h00000033, 1'b0, 3, 1'b1);
    drain_q("lb_pos");
  endtask

  task automatic test_split_load();
    mem[0] <= 32'h44332211;
    mem[1] <= 32'h88776655;
`ifdef MISALIGN_TRAP_EN
    send(1'b1, 2'd2, 1'b0, 32'h102, 32'h0, 32'h0, 1'b1, 1, 1'b1);
    @(negedge clk);
    tests_run++;
    if ({bus.mem_re, bus.mem_we, bus.mem_be} !== 6'h0) begin
      fails++;
      $display("FAIL trap_strobes: re/we/be=%b required 0", {bus.mem_re, bus.mem_we, bus.mem_be});
    end
`else
    send(1'b1, 2'd2, 1'b0, 32'h102, 32'h0, 32'h66554433, 1'b0, 4, 1'b1);
    @(negedge clk);
    tests_run++;
    if ({bus.mem_re, bus.mem_be, bus.mem_addr} !== {1'b1, 4'b1100, 32'h100}) begin
      fails++;
      $display("FAIL split_lw_c1: re/be/addr=%h required %h",
               {bus.mem_re, bus.mem_be, bus.mem_addr}, {1'b1, 4'b1100, 32'h100});
    end
    @(negedge clk);
    tests_run++;
    if ({bus.mem_re, bus.mem_be, bus.mem_addr} !== {1'b1, 4'b0011, 32'h104}) begin
      fails++;
      $display("FAIL split_lw_c2: re/be/addr=%h required %h",
               {bus.mem_re, bus.mem_be, bus.mem_addr}, {1'b1, 4'b0011, 32'h104});
    end
`endif
    drain_q("split_lw");
  endtask

  task automatic test_stores();
    mem[0] <= 32'h0;
    mem[1] <= 32'h0;
    mem[2] <= 32'h0;
    send(1'b0, 2'd2, 1'b0, 32'h100, 32'h12345678, 32'h0, 1'b0, 2, 1'b1);
    @(negedge clk);
    tests_run++;
    if ({bus.mem_we, bus.mem_re, bus.mem_be, bus.mem_wdata} !== {1'b1, 1'b0, 4'hF, 32'h12345678}) begin
      fails++;
      $display("FAIL sw_c1: we/re/be/wdata=%h required %h",
               {bus.mem_we, bus.mem_re, bus.mem_be, bus.mem_wdata}, {1'b1, 1'b0, 4'hF, 32'h12345678});
    end
    drain_q("sw");
    send(1'b0, 2'd0, 1'b0, 32'h101, 32'hFFFFFF5A, 32'h0, 1'b0, 2, 1'b1);
    @(negedge clk);
    tests_run++;
    if ({bus.mem_be, bus.mem_wdata} !== {4'b0010, 32'h00005A00}) begin
      fails++;
      $display("FAIL sb_c1: be/wdata=%h required %h", {bus.mem_be, bus.mem_wdata}, {4'b0010, 32'h00005A00});
    end
    drain_q("sb");
    tests_run++;
    if (mem[0] !== 32'h12345A78) begin
      fails++;
      $display("FAIL sb_mem: mem=%h required 12345a78", mem[0]);
    end
`ifdef MISALIGN_TRAP_EN
    send(1'b0, 2'd1, 1'b0, 32'h107, 32'h0000ABCD, 32'h0, 1'b1, 1, 1'b1);
    drain_q("trap_sh");
    tests_run++;
    if ({mem[1], mem[2]} !== 64'h0) begin
      fails++;
      $display("FAIL trap_sh_mem: mem=%h required 0", {mem[1], mem[2]});
    end
`else
    send(1'b0, 2'd1, 1'b0, 32'h107, 32'h0000ABCD, 32'h0, 1'b0, 3, 1'b1);
    @(negedge clk);
    tests_run++;
    if ({bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata[31:24]} !== {1'b1, 4'b1000, 32'h104, 8'hCD}) begin
      fails++;
      $display("FAIL split_sh_c1: we/be/addr/wd=%h required %h",
               {bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata[31:24]}, {1'b1, 4'b1000, 32'h104, 8'hCD});
    end
    @(negedge clk);
    tests_run++;
    if ({bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata[7:0]} !== {1'b1, 4'b0001, 32'h108, 8'hAB}) begin
      fails++;
      $display("FAIL split_sh_c2: we/be/addr/wd=%h required %h",
               {bus.mem_we, bus.mem_be, bus.mem_addr, bus.mem_wdata[7:0]}, {1'b1, 4'b0001, 32'h108, 8'hAB});
    end
    drain_q("split_sh");
    tests_run++;
    if ({mem[1], mem[2]} !== {32'hCD000000, 32'h000000AB}) begin
      fails++;
      $display("FAIL split_sh_mem: mem=%h required cd000000000000ab", {mem[1], mem[2]});
    end
`endif
  endtask

  task automatic test_reset_mid();
    logic [31:0] a;
    logic [3:0]  be;
`ifdef MISALIGN_TRAP_EN
    a = 32'h100; be = 4'hF;
`else
    a = 32'h102; be = 4'b1100;
`endif
    send(1'b1, 2'd2, 1'b0, a, 32'h0, 32'h0, 1'b0, 0, 1'b0);
    @(negedge clk);
    tests_run++;
    if ({bus.mem_re, bus.mem_be} !== {1'b1, be}) begin
      fails++;
      $display("FAIL rstmid_c1: re/be=%b required %b", {bus.mem_re, bus.mem_be}, {1'b1, be});
    end
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      tests_run++;
      if ({bus.req_ready, bus.mem_re, bus.mem_we, bus.mem_be, bus.rsp_valid} !== 8'b1000_0000) begin
        fails++;
        $display("FAIL rstmid_quiet: ready/re/we/be/rsp=%b required 10000000",
                 {bus.req_ready, bus.mem_re, bus.mem_we, bus.mem_be, bus.rsp_valid});
      end
    end
    mem[0] <= 32'hCAFEF00D;
    send(1'b1, 2'd2, 1'b0, 32'h100, 32'h0, 32'hCAFEF00D, 1'b0, 3, 1'b1);
    drain_q("rstmid_after");
  endtask

  task automatic test_illegal_and_wrap();
    send(1'b1, 2'd3, 1'b0, 32'h100, 32'h0, 32'h0, 1'b1, 1, 1'b1);
    @(negedge clk);
    tests_run++;
    if ({bus.mem_re, bus.mem_we, bus.mem_be} !== 6'h0) begin
      fails++;
      $display("FAIL illegal_strobes: re/we/be=%b required 0", {bus.mem_re, bus.mem_we, bus.mem_be});
    end
    drain_q("illegal_ld");
    send(1'b0, 2'd3, 1'b0, 32'h104, 32'h55555555, 32'h0, 1'b1, 1, 1'b1);
    drain_q("illegal_st");
    mem[63] <= 32'h7F001122;
    mem[0]  <= 32'h998877E6;
`ifdef MISALIGN_TRAP_EN
    send(1'b1, 2'd1, 1'b1, 32'hFFFFFFFF, 32'h0, 32'h0, 1'b1, 1, 1'b1);
`else
    send(1'b1, 2'd1, 1'b1, 32'hFFFFFFFF, 32'h0, 32'hFFFFE67F, 1'b0, 4, 1'b1);
    @(negedge clk);
    tests_run++;
    if ({bus.mem_be, bus.mem_addr} !== {4'b1000, 32'hFFFFFFFC}) begin
      fails++;
      $display("FAIL wrap_c1: be/addr=%h required %h", {bus.mem_be, bus.mem_addr}, {4'b1000, 32'hFFFFFFFC});
    end
    @(negedge clk);
    tests_run++;
    if ({bus.mem_re, bus.mem_be, bus.mem_addr} !== {1'b1, 4'b0001, 32'h0}) begin
      fails++;
      $display("FAIL wrap_c2: re/be/addr=%h required %h",
               {bus.mem_re, bus.mem_be, bus.mem_addr}, {1'b1, 4'b0001, 32'h0});
    end
`endif
    drain_q("wrap");
  endtask

  task automatic test_back_to_back();
    mem[2] <= 32'h0;
    send(1'b0, 2'd2, 1'b0, 32'h108, 32'h11111111, 32'h0, 1'b0, 2, 1'b1);
    @(negedge clk);
    // Second request held from cycle 1; must only be taken once back in IDLE.
    bus.req_load  = 1'b0;
    bus.req_dw    = 2'd0;
    bus.req_sign  = 1'b0;
    bus.req_addr  = 32'h10A;
    bus.req_wdata = 32'h000000EE;
    bus.req_valid = 1'b1;
    exp_q.push_back('{rdata: 32'h0, err: 1'b0, lat: 2});
    tests_run++;
    if (bus.req_ready !== 1'b0) begin
      fails++;
      $display("FAIL b2b_ready_c1: req_ready=%b required 0", bus.req_ready);
    end
    @(negedge clk);
    tests_run++;
    if (bus.req_ready !== 1'b0) begin
      fails++;
      $display("FAIL b2b_ready_c2: req_ready=%b required 0", bus.req_ready);
    end
    @(negedge clk);
    tests_run++;
    if (bus.req_ready !== 1'b1) begin
      fails++;
      $display("FAIL b2b_ready_c3: req_ready=%b required 1", bus.req_ready);
    end
    @(posedge clk);
    #1;
    accept_cyc    = cyc;
    bus.req_valid = 1'b0;
    drain_q("b2b");
    tests_run++;
    if (mem[2] !== 32'h11EE1111) begin
      fails++;
      $display("FAIL b2b_mem: mem=%h required 11ee1111", mem[2]);
    end
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_load  = 1'b0;
    bus.req_dw    = '0;
    bus.req_sign  = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
    test_reset();
    test_aligned_load();
    test_byte_loads();
    test_split_load();
    test_stores();
    test_reset_mid();
    test_illegal_and_wrap();
    test_back_to_back();
    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end

endmodule
